// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin arbitrated mux.
// Imported by the interface, the arbiter and the top level.
package mux_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Channel index width; never narrower than one bit.
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// N:1 handshake bundle: N producer channels in, one consumer out.
// slave is the mux side, master is the producer/consumer side.
interface rr_arb_mux_if
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 8
);

  localparam int SEL_W = idx_w(NUM_INPUTS);

  logic [NUM_INPUTS-1:0] in_valid;
  logic [WIDTH-1:0]      in_data [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

endinterface

// File: rtl/rr_arbiter.sv
// One-of-N arbiter, round-robin or fixed priority.
// Owns the last-grant pointer used by the round-robin search.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        NUM_INPUTS = 4,
  parameter arb_mode_e ARB_MODE   = ARB_RR,
  localparam int       SEL_W      = idx_w(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic                  advance,
  output logic [NUM_INPUTS-1:0] gnt,
  output logic [SEL_W-1:0]      gnt_idx,
  output logic                  any_gnt
);

  logic [SEL_W-1:0] ptr;
  int               d;
  int               best;

  // d is each channel's distance from the search start;
  // the smallest distance among requesters wins.
  always_comb begin
    gnt_idx = '0;
    any_gnt = 1'b0;
    best    = NUM_INPUTS;
    d       = 0;
    for (int c = 0; c < NUM_INPUTS; c++) begin
      if (ARB_MODE == ARB_FIXED) begin
        d = c;
      end else begin
        d = c - int'(ptr) - 1;
        if (d < 0) d = d + NUM_INPUTS;
      end
      if (req[c] && d < best) begin
        best    = d;
        gnt_idx = SEL_W'(c);
        any_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int c = 0; c < NUM_INPUTS; c++) begin
      gnt[c] = any_gnt && (gnt_idx == SEL_W'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= SEL_W'(NUM_INPUTS - 1);
    end else if (advance && any_gnt) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N:1 mux with valid/ready on every port.
// An internal arbiter picks the channel loaded into the output register.
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int        NUM_INPUTS = 4,
  parameter int        WIDTH      = 8,
  parameter arb_mode_e ARB_MODE   = ARB_RR
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arb_mux_if.slave bus
);

  localparam int SEL_W = idx_w(NUM_INPUTS);

  logic                  load_en;
  logic [NUM_INPUTS-1:0] gnt;
  logic [SEL_W-1:0]      gnt_idx;
  logic                  any_gnt;
  logic [WIDTH-1:0]      mux_data;

  logic                  q_valid;
  logic [WIDTH-1:0]      q_data;
  logic [SEL_W-1:0]      q_sel;

  // rst_n gates load_en so nothing is accepted while in reset.
  assign load_en = rst_n & (~q_valid | bus.out_ready);

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .ARB_MODE   (ARB_MODE)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.in_valid),
    .advance (load_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign bus.in_ready = gnt & {NUM_INPUTS{load_en}};

  always_comb begin
    mux_data = '0;
    for (int c = 0; c < NUM_INPUTS; c++) begin
      if (gnt[c]) mux_data = bus.in_data[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_sel   <= '0;
    end else if (load_en) begin
      if (any_gnt) begin
        q_valid <= 1'b1;
        q_data  <= mux_data;
        q_sel   <= gnt_idx;
      end else begin
        q_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = q_valid;
  assign bus.out_data  = q_data;
  assign bus.out_sel   = q_sel;

endmodule
